mult_div_hilo: RTL and testbench

Iterative 32-bit multiply/divide unit for the MIPS datapath, directly downstream of the register file (banco_reg). It consumes ReadData1 (rs) and ReadData2 (rt) and executes MULT/MULTU/DIV/DIVU over multiple cycles into private HI/LO registers. MTHI/MTLO writes are also supported. Hi/Lo feed the MFHI/MFLO write-back path.

---
 rtl/mult_div_hilo.sv | 167 ++++++++++++++++
 tb/tb_mult_div_hilo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_hilo.sv
// mult_div_hilo: iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO pair, plus MTHI/MTLO.
// Defining MULTDIV_MADD_EN turns Acc=1 multiplies into MADD/MADDU accumulates into {Hi,Lo}.

// Purpose: one shift-add / restoring shift-subtract step per clock, sign fix-up, HI/LO write.
// Latency: Start edge N -> Done pulse and new Hi/Lo after edge N+33 (divide by zero: N+1).
// Backpressure: none; Start while Busy is dropped, caller must wait for Done.
module mult_div_hilo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic             Acc,
   input  logic [WIDTH-1:0] ReadData1,
   input  logic [WIDTH-1:0] ReadData2,
   input  logic             HiWrite,
   input  logic             LoWrite,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DZ} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_opd;
   logic [WIDTH-1:0] r_ph;
   logic [WIDTH-1:0] r_pl;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_div;
   logic             r_qneg;
   logic             r_rneg;
   logic             r_busy;
   logic             r_done;
   logic             r_dz;

   logic             w_is_div;
   logic             w_a_neg;
   logic             w_b_neg;
   logic             w_dz;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;

   assign w_is_div = Op[1];
   assign w_a_neg  = Op[0] & ReadData1[WIDTH-1];
   assign w_b_neg  = Op[0] & ReadData2[WIDTH-1];
   assign w_abs_a  = w_a_neg ? -ReadData1 : ReadData1;
   assign w_abs_b  = w_b_neg ? -ReadData2 : ReadData2;
   assign w_dz     = w_is_div & (ReadData2 == '0);

   // Multiply: r_ph:r_pl is the running product, multiplier shifting out of r_pl.
   // Divide: r_ph is the partial remainder, dividend shifts out of r_pl as quotient shifts in.
   logic [WIDTH:0]   w_msum;
   logic [WIDTH:0]   w_dshift;
   logic [WIDTH+1:0] w_ddiff;
   logic             w_qbit;

   assign w_msum   = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_opd} : '0);
   assign w_dshift = {r_ph, r_pl[WIDTH-1]};
   assign w_ddiff  = {1'b0, w_dshift} - {2'b0, r_opd};
   assign w_qbit   = ~w_ddiff[WIDTH+1];

   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_mres;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic               w_unused_bits;

   assign w_prod = r_qneg ? -{r_ph, r_pl} : {r_ph, r_pl};
   assign w_quo  = r_qneg ? -r_pl : r_pl;
   assign w_rem  = r_rneg ? -r_ph : r_ph;

`ifdef MULTDIV_MADD_EN
   logic r_madd;
   assign w_mres        = r_madd ? ({r_hi, r_lo} + w_prod) : w_prod;
   assign w_unused_bits = w_ddiff[WIDTH];
`else
   assign w_mres        = w_prod;
   assign w_unused_bits = w_ddiff[WIDTH] ^ Acc;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_opd   <= '0;
         r_ph    <= '0;
         r_pl    <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_div   <= 1'b0;
         r_qneg  <= 1'b0;
         r_rneg  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dz    <= 1'b0;
`ifdef MULTDIV_MADD_EN
         r_madd  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         r_dz   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  r_busy  <= 1'b1;
                  r_div   <= w_is_div;
                  r_cnt   <= '0;
                  r_ph    <= '0;
                  r_rneg  <= w_a_neg;
                  r_qneg  <= w_a_neg ^ w_b_neg;
                  r_opd   <= w_is_div ? w_abs_b : w_abs_a;
                  r_pl    <= w_is_div ? w_abs_a : w_abs_b;
`ifdef MULTDIV_MADD_EN
                  r_madd  <= Acc & ~w_is_div;
`endif
                  r_state <= w_dz ? S_DZ : S_RUN;
               end else begin
                  if (HiWrite) r_hi <= ReadData1;
                  if (LoWrite) r_lo <= ReadData1;
               end
            end
            S_RUN: begin
               if (r_div) begin
                  r_ph <= w_qbit ? w_ddiff[WIDTH-1:0] : w_dshift[WIDTH-1:0];
                  r_pl <= {r_pl[WIDTH-2:0], w_qbit};
               end else begin
                  {r_ph, r_pl} <= {w_msum, r_pl[WIDTH-1:1]};
               end
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(WIDTH-1)) r_state <= S_FIX;
            end
            S_FIX: begin
               if (r_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end else begin
                  {r_hi, r_lo} <= w_mres;
               end
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            S_DZ: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_dz    <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign Busy      = r_busy;
   assign Done      = r_done;
   assign DivByZero = r_dz;
   assign Hi        = r_hi;
   assign Lo        = r_lo;

endmodule

// File: tb/tb_mult_div_hilo.sv
// Bench for mult_div_hilo: directed plan steps then random ops against an arithmetic reference.
// Honours MULTDIV_MADD_EN the same way the design does.
module tb_mult_div_hilo;
   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [1:0]  Op;
   logic        Acc;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic        HiWrite;
   logic        LoWrite;
   logic        Busy;
   logic        Done;
   logic        DivByZero;
   logic [31:0] Hi;
   logic [31:0] Lo;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   always #5 clk = ~clk;

   mult_div_hilo #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .Start     (Start),
      .Op        (Op),
      .Acc       (Acc),
      .ReadData1 (ReadData1),
      .ReadData2 (ReadData2),
      .HiWrite   (HiWrite),
      .LoWrite   (LoWrite),
      .Busy      (Busy),
      .Done      (Done),
      .DivByZero (DivByZero),
      .Hi        (Hi),
      .Lo        (Lo)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference result {Hi,Lo} from plain 64-bit arithmetic.
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic acc,
                                         input logic [63:0] hl);
      logic [63:0] r;
      longint      sa;
      longint      sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'd0:    r = {32'd0, a} * {32'd0, b};
         2'd1:    r = 64'(sa * sb);
         2'd2:    r = (b == 32'd0) ? hl : {a % b, a / b};
         default: r = (b == 32'd0) ? hl : {32'(sa % sb), 32'(sa / sb)};
      endcase
`ifdef MULTDIV_MADD_EN
      if (acc && !op[1]) r = r + hl;
`else
      if (acc === 1'bx) r = 'x;
`endif
      return r;
   endfunction

   task automatic mt(input logic hw, input logic lw, input logic [31:0] val);
      HiWrite = hw;
      LoWrite = lw;
      ReadData1 = val;
      tick();
      HiWrite = 1'b0;
      LoWrite = 1'b0;
      if (hw) m_hi = val;
      if (lw) m_lo = val;
   endtask

   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic acc, input logic hw, input logic lw, input string tag);
      logic [63:0] e;
      int          k;
      int          nb;
      logic        dz;
      dz = op[1] && (b == 32'd0);
      e  = model(op, a, b, acc, {m_hi, m_lo});
      Op = op; ReadData1 = a; ReadData2 = b; Acc = acc;
      HiWrite = hw; LoWrite = lw; Start = 1'b1;
      tick();
      Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
      ReadData1 = $urandom; ReadData2 = $urandom; Acc = 1'($urandom);
      k = 0;
      nb = 0;
      while (Done !== 1'b1 && k < 60) begin
         if (Busy === 1'b1) nb++;
         tick();
         k++;
      end
      chk({tag, "/latency"}, 64'(k), dz ? 64'd1 : 64'd33);
      if (!dz) chk({tag, "/busy_cycles"}, 64'(nb), 64'd33);
      chk({tag, "/divbyzero"}, 64'(DivByZero), 64'(dz));
      chk({tag, "/busy_at_done"}, 64'(Busy), 64'd0);
      chk({tag, "/hi"}, 64'(Hi), 64'(e[63:32]));
      chk({tag, "/lo"}, 64'(Lo), 64'(e[31:0]));
      {m_hi, m_lo} = e;
      tick();
      chk({tag, "/done_single_pulse"}, 64'(Done), 64'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int nd;
      reset = 1'b1; Start = 1'b0; Op = 2'd0; Acc = 1'b0;
      HiWrite = 1'b0; LoWrite = 1'b0; ReadData1 = '0; ReadData2 = '0;
      repeat (3) tick();
      chk("reset/hi", 64'(Hi), 64'd0);
      chk("reset/lo", 64'(Lo), 64'd0);
      chk("reset/busy", 64'(Busy), 64'd0);
      chk("reset/done", 64'(Done), 64'd0);
      chk("reset/dz", 64'(DivByZero), 64'd0);
      reset = 1'b0;
      tick();

      do_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, "t1_multu");
      chk("t1/hi_const", 64'(Hi), 64'hFFFFFFFE);
      chk("t1/lo_const", 64'(Lo), 64'h00000001);

      do_op(2'd1, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, 1'b0, "t2_mult_neg");
      chk("t2a/hi_const", 64'(Hi), 64'hFFFFFFFF);
      chk("t2a/lo_const", 64'(Lo), 64'hFFFFFFEB);
      do_op(2'd1, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, "t2_mult_min");
      chk("t2b/hi_const", 64'(Hi), 64'h40000000);
      chk("t2b/lo_const", 64'(Lo), 64'h0);

      do_op(2'd2, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, "t3_divu");
      chk("t3a/lo_const", 64'(Lo), 64'd14);
      chk("t3a/hi_const", 64'(Hi), 64'd2);
      do_op(2'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 1'b0, "t3_div_neg");
      chk("t3b/lo_const", 64'(Lo), 64'hFFFFFFFD);
      chk("t3b/hi_const", 64'(Hi), 64'hFFFFFFFF);
      do_op(2'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, "t3_div_wrap");
      chk("t3c/lo_const", 64'(Lo), 64'h80000000);
      chk("t3c/hi_const", 64'(Hi), 64'h0);

      mt(1'b1, 1'b1, 32'h33);
      chk("t4/both_hi", 64'(Hi), 64'h33);
      chk("t4/both_lo", 64'(Lo), 64'h33);
      mt(1'b1, 1'b0, 32'h11);
      mt(1'b0, 1'b1, 32'h22);
      chk("t4/mthi", 64'(Hi), 64'h11);
      chk("t4/mtlo", 64'(Lo), 64'h22);
      // HiWrite/LoWrite raised together with Start must lose to Start.
      do_op(2'd3, 32'd5, 32'd0, 1'b0, 1'b1, 1'b1, "t4_div0");
      chk("t4/hi_kept", 64'(Hi), 64'h11);
      chk("t4/lo_kept", 64'(Lo), 64'h22);

      Op = 2'd0; ReadData1 = 32'd3; ReadData2 = 32'd4; Acc = 1'b0; Start = 1'b1;
      tick();
      Start = 1'b0;
      repeat (4) tick();
      Start = 1'b1; ReadData1 = 32'hDEAD; ReadData2 = 32'd9; HiWrite = 1'b1;
      tick();
      Start = 1'b0; HiWrite = 1'b0;
      k = 5;
      while (Done !== 1'b1 && k < 60) begin
         tick();
         k++;
      end
      chk("t5/latency", 64'(k), 64'd33);
      chk("t5/lo", 64'(Lo), 64'd12);
      chk("t5/hi", 64'(Hi), 64'd0);
      m_hi = '0; m_lo = 32'd12;
      Op = 2'd0; ReadData1 = 32'd5; ReadData2 = 32'd6; Start = 1'b1;
      tick();
      Start = 1'b0;
      chk("t5/start_in_done_accepted", 64'(Busy), 64'd1);
      repeat (9) tick();
      reset = 1'b1;
      tick();
      chk("t5/reset_hi", 64'(Hi), 64'd0);
      chk("t5/reset_lo", 64'(Lo), 64'd0);
      chk("t5/reset_busy", 64'(Busy), 64'd0);
      chk("t5/reset_done", 64'(Done), 64'd0);
      reset = 1'b0;
      m_hi = '0; m_lo = '0;
      nd = 0;
      repeat (40) begin
         tick();
         if (Done !== 1'b0) nd++;
      end
      chk("t5/no_done_after_reset", 64'(nd), 64'd0);

      mt(1'b1, 1'b0, 32'd0);
      mt(1'b0, 1'b1, 32'd5);
      do_op(2'd0, 32'd2, 32'd3, 1'b1, 1'b0, 1'b0, "t6_acc");
`ifdef MULTDIV_MADD_EN
      chk("t6/lo_const", 64'(Lo), 64'd11);
`else
      chk("t6/lo_const", 64'(Lo), 64'd6);
`endif
      chk("t6/hi_const", 64'(Hi), 64'd0);

      for (int i = 0; i < 40; i++) begin
         logic [1:0]  rop;
         logic [31:0] ra;
         logic [31:0] rb;
         if ($urandom_range(3) == 0) mt(1'($urandom), 1'($urandom), $urandom);
         rop = 2'($urandom);
         ra  = $urandom;
         case ($urandom_range(5))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(15));
            2:       rb = 32'hFFFFFFFF;
            default: rb = $urandom;
         endcase
         do_op(rop, ra, rb, 1'($urandom), 1'b0, 1'b0, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
